// File: rtl/reg_wb_queue.sv
// Write-back queue and sequencer for the 8x32 register file write port.
// Optional: define WB_FORWARD_EN to add the fwd_* store-to-read forwarding ports.
module reg_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_rd,
  input  logic [1:0]  req_mode,
  input  logic [31:0] req_data,
  input  logic        wb_stall,
  output logic [1:0]  wb_we,
  output logic [2:0]  wb_enc,
  output logic [31:0] wb_data,
  output logic [7:0]  pending_mask,
  output logic [2:0]  occupancy,
  output logic        idle
`ifdef WB_FORWARD_EN
  ,
  input  logic [2:0]  fwd_rd,
  output logic        fwd_hit,
  output logic        fwd_partial,
  output logic [31:0] fwd_data
`endif
);

  localparam int AW = (DEPTH > 4) ? 3 : (DEPTH > 2) ? 2 : 1;

  logic [2:0]    q_rd_q   [DEPTH];
  logic [2:0]    q_rd_d   [DEPTH];
  logic [1:0]    q_mode_q [DEPTH];
  logic [1:0]    q_mode_d [DEPTH];
  logic [31:0]   q_data_q [DEPTH];
  logic [31:0]   q_data_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0]    occ_q, occ_d;
  logic [1:0]    we_q, we_d;
  logic [2:0]    enc_q, enc_d;
  logic [31:0]   data_q, data_d;
  logic [2:0]    cnt_q [8];
  logic [2:0]    cnt_d [8];
  logic          accept, empty, push, pop;
  logic [33:0]   exp_v;

  // Returns {we, data} for a request mode.
  function automatic logic [33:0] expand(logic [1:0] m, logic [31:0] d);
    logic [33:0] r;
    case (m)
      2'b00:   r = {2'b11, d};
      2'b01:   r = {2'b01, 16'h0, d[15:0]};
      2'b10:   r = {2'b10, d[15:0], 16'h0};
      default: r = {2'b11, 16'h0, d[15:0]};
    endcase
    return r;
  endfunction

  function automatic logic [AW-1:0] nxt(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign req_ready = (occ_q < 3'(DEPTH));
  assign wb_we     = we_q;
  assign wb_enc    = enc_q;
  assign wb_data   = data_q;
  assign occupancy = occ_q;
  assign idle      = (occ_q == 3'd0) && (we_q == 2'b00);

  // FIFO push/pop, bypass and output register next state.
  always_comb begin
    accept   = req_valid && req_ready;
    empty    = (occ_q == 3'd0);
    pop      = !wb_stall && !empty;
    push     = accept && (wb_stall || !empty);
    q_rd_d   = q_rd_q;
    q_mode_d = q_mode_q;
    q_data_d = q_data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    we_d     = 2'b00;
    enc_d    = enc_q;
    data_d   = data_q;
    exp_v    = '0;
    if (pop) begin
      exp_v    = expand(q_mode_q[rd_ptr_q], q_data_q[rd_ptr_q]);
      we_d     = exp_v[33:32];
      data_d   = exp_v[31:0];
      enc_d    = q_rd_q[rd_ptr_q];
      rd_ptr_d = nxt(rd_ptr_q);
    end else if (!wb_stall && accept) begin
      exp_v  = expand(req_mode, req_data);
      we_d   = exp_v[33:32];
      data_d = exp_v[31:0];
      enc_d  = req_rd;
    end
    if (push) begin
      q_rd_d[wr_ptr_q]   = req_rd;
      q_mode_d[wr_ptr_q] = req_mode;
      q_data_d[wr_ptr_q] = req_data;
      wr_ptr_d           = nxt(wr_ptr_q);
    end
    occ_d = occ_q + {2'b00, push} - {2'b00, pop};
  end

  // Per-register pending counters: up on accept, down when a write retires.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((accept && req_rd == 3'(i)) &&
          !(we_q != 2'b00 && enc_q == 3'(i)))
        cnt_d[i] = cnt_q[i] + 3'd1;
      else if (!(accept && req_rd == 3'(i)) &&
               (we_q != 2'b00 && enc_q == 3'(i)))
        cnt_d[i] = cnt_q[i] - 3'd1;
      pending_mask[i] = (cnt_q[i] != 3'd0);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_q[i]   <= '0;
        q_mode_q[i] <= '0;
        q_data_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      we_q     <= '0;
      enc_q    <= '0;
      data_q   <= '0;
    end else begin
      q_rd_q   <= q_rd_d;
      q_mode_q <= q_mode_d;
      q_data_q <= q_data_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      we_q     <= we_d;
      enc_q    <= enc_d;
      data_q   <= data_d;
    end
  end

`ifdef WB_FORWARD_EN
  logic [AW-1:0] fidx;
  logic [33:0]   fexp;

  // Youngest pending write to fwd_rd wins; the live output is the oldest.
  always_comb begin
    fwd_hit     = 1'b0;
    fwd_partial = 1'b0;
    fwd_data    = '0;
    fidx        = rd_ptr_q;
    fexp        = '0;
    if (we_q != 2'b00 && enc_q == fwd_rd) begin
      fwd_hit     = (we_q == 2'b11);
      fwd_partial = (we_q != 2'b11);
      fwd_data    = (we_q == 2'b11) ? data_q : '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (3'(i) < occ_q && q_rd_q[fidx] == fwd_rd) begin
        fexp        = expand(q_mode_q[fidx], q_data_q[fidx]);
        fwd_hit     = (fexp[33:32] == 2'b11);
        fwd_partial = (fexp[33:32] != 2'b11);
        fwd_data    = (fexp[33:32] == 2'b11) ? fexp[31:0] : '0;
      end
      fidx = nxt(fidx);
    end
  end
`endif

endmodule
